// File: rtl/l1_inval_queue_if.sv
// rtl/l1_inval_queue_if.sv - invalidation request stream and L1 req/ack bundle
interface l1_inval_queue_if #(
   parameter int unsigned AddrWidth = 64
);
   logic [AddrWidth-1:0] inval_addr;
   logic                 inval_valid;
   logic                 inval_ready;
   logic [AddrWidth-1:0] cache_inval_addr;
   logic                 cache_inval_req;
   logic                 cache_inval_ack;

   // Environment side: produces invalidations and answers the L1 request
   modport master (
      output inval_addr,
      output inval_valid,
      output cache_inval_ack,
      input  inval_ready,
      input  cache_inval_addr,
      input  cache_inval_req
   );

   // Queue side: accepts invalidations and drives the L1 request
   modport slave (
      input  inval_addr,
      input  inval_valid,
      input  cache_inval_ack,
      output inval_ready,
      output cache_inval_addr,
      output cache_inval_req
   );
endinterface

// File: rtl/l1_inval_queue.sv
// rtl/l1_inval_queue.sv - deduplicating L1 line-invalidation queue with req/ack issue
module l1_inval_queue #(
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned L1LineWidth = 16,
   parameter int unsigned Depth       = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   l1_inval_queue_if.slave     bus,
   output logic                busy_o,
   output logic [15:0]         dup_cnt_o
);
   localparam int unsigned LB = $clog2(L1LineWidth);
   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned CW = PW + 1;
   localparam logic [AddrWidth-1:0] LineMask = {{(AddrWidth-LB){1'b1}}, {LB{1'b0}}};

   typedef enum logic {IDLE, BUSY} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] mem_q [Depth];
   logic [PW-1:0]        wptr_q, rptr_q, tail_ptr;
   logic [CW-1:0]        cnt_q;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [15:0]          dup_cnt_q;
   logic [AddrWidth-1:0] line;
   logic                 empty, full, hs, dup_hit, accept, bypass_ok;
   logic                 load_bypass, pop, push;

   assign line      = bus.inval_addr & LineMask;
   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(Depth));
   assign tail_ptr  = wptr_q - PW'(1);
   assign hs        = bus.inval_valid & ~full;

   // Duplicates compare against the newest queued line, or the in-flight line once the queue is empty
   assign dup_hit   = hs & ((~empty & (line == mem_q[tail_ptr])) |
                            (empty & (state_q == BUSY) & (line == addr_q)));
   assign accept    = hs & ~dup_hit & ~flush_i;
   assign bypass_ok = accept & empty;
   assign push      = accept & ~load_bypass;

   assign bus.inval_ready      = ~full;
   assign bus.cache_inval_req  = (state_q == BUSY);
   assign bus.cache_inval_addr = addr_q;
   assign busy_o               = (state_q == BUSY) | ~empty;
   assign dup_cnt_o            = dup_cnt_q;

   // Issue FSM: choose the next in-flight line from the queue head or a bypassing request
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pop         = 1'b0;
      load_bypass = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               addr_d  = mem_q[rptr_q];
               state_d = BUSY;
            end else if (bypass_ok) begin
               load_bypass = 1'b1;
               addr_d      = line;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (bus.cache_inval_ack) begin
               if (!empty) begin
                  pop    = 1'b1;
                  addr_d = mem_q[rptr_q];
               end else if (bypass_ok) begin
                  load_bypass = 1'b1;
                  addr_d      = line;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, in-flight address, pointers, occupancy and duplicate counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         dup_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         if (dup_hit && (dup_cnt_q != 16'hFFFF)) begin
            dup_cnt_q <= dup_cnt_q + 16'd1;
         end
         if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
         end
      end
   end

   // Queue storage needs no reset; occupancy is tracked by cnt_q
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= line;
      end
   end
endmodule
